// File: rtl/simplebus_arb_pkg.sv
// Shared types and constants for the simplebus arbiter and its interface.
package simplebus_arb_pkg;

  localparam int FOO_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  // An index into n items needs at least one bit, even when n == 1.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simplebus_if.sv
// Shared simplebus: a single foo field driven by exactly one master.
interface simplebus;
  import simplebus_arb_pkg::*;

  logic [FOO_W-1:0] foo;

  modport master (output foo);
  modport slave  (input  foo);

endinterface

// File: rtl/simplebus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping past N-1.
module rr_pick
  import simplebus_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k stays below 2N, so one conditional subtract is a full modulo.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      pos = sum[IW-1:0];
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/simplebus_arbiter.sv
// Round-robin owner of a shared simplebus with bounded hold and a one-cycle
// turnaround between owners.
module simplebus_arbiter
  import simplebus_arb_pkg::*;
#(
  parameter int               NREQ     = 4,
  parameter int               MAXHOLD  = 8,
  parameter logic [FOO_W-1:0] IDLE_VAL = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*FOO_W-1:0] wdata,
  input  logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  timeout,
  output arb_state_t            dbg_state,
  simplebus.master              thebus
);

  localparam int IW = idx_w(NREQ);
  localparam int HW = $clog2(MAXHOLD + 1);

  // Handshake: a requester holds req high until it is finished; gnt follows
  // one cycle after req is sampled in IDLE and stays until the owner pulses
  // done, drops req, or has held the bus for MAXHOLD cycles.
  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic [FOO_W-1:0] wdata_arr [NREQ];
  logic             own_done, own_req, at_max, release_now;
  logic [IW-1:0]    next_ptr;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign wdata_arr[i] = wdata[FOO_W*i +: FOO_W];
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign own_done    = done[owner_q];
  assign own_req     = req[owner_q];
  assign at_max      = (hold_cnt_q >= HW'(MAXHOLD));
  assign release_now = own_done | ~own_req | at_max;
  assign next_ptr    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d    = ARB_GRANT;
          gnt_d      = pick_onehot;
          owner_d    = pick_idx;
          hold_cnt_d = HW'(1);
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          state_d    = ARB_TURN;
          gnt_d      = '0;
          rr_ptr_d   = next_ptr;
          hold_cnt_d = '0;
          // Only a pure hold-limit release counts as a timeout.
          timeout_d  = at_max & own_req & ~own_done;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ARB_TURN: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q == ARB_GRANT);
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;
  assign thebus.foo = busy ? wdata_arr[owner_q] : IDLE_VAL;

endmodule
